alu_div_seq: RTL and testbench
==============================

// Module: alu_div_seq
// PURPOSE
//  Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) that drives the shared
//  single-cycle ALU through its ALU_DA/ALU_DB/ALU_CTL/ALU_DC interface.
//  Sits beside EX; EX issues a request, the sequencer owns the ALU until the response.
//  Restoring division, two ALU ops (compare, subtract) per quotient bit.
// PARAMETERS
//  XLEN      32  operand width; only 32 is supported
//  FIX_LAT   1   1 = SUB cycle always executed (fixed latency); 0 is not supported
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     async active-low reset
//  req_valid  in   1     request valid
//  req_ready  out  1     sequencer can accept (high only in IDLE)
//  req_op     in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  req_a      in   32    dividend
//  req_b      in   32    divisor
//  rsp_valid  out  1     result valid, held until rsp_ready
//  rsp_ready  in   1     consumer accepts result
//  rsp_data   out  32    quotient or remainder
//  busy       out  1     ALU owned by sequencer (state != IDLE)
//  alu_da     out  32    to ALU_DA
//  alu_db     out  32    to ALU_DB
//  alu_ctl    out  4     to ALU_CTL
//  alu_dc     in   32    from ALU_DC
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, busy=0,
//   alu_da=alu_db=0, alu_ctl=4'b0000; all internal regs 0. Reset mid-operation aborts, no response.
//  ALU codes used: ADD 4'b0000 (idle), SUB 4'b0010 (no ovf flag), SLTU 4'b1000.
//  Accept: req_valid & req_ready at edge; op/a/b latched; signed = ~req_op[0].
//  Special cases decided at accept, go straight to DONE (rsp_valid next cycle):
//   b==0: quotient 32'hFFFFFFFF, remainder a.  signed & a==32'h80000000 & b==32'hFFFFFFFF:
//   quotient 32'h80000000, remainder 0.
//  States: IDLE -> (signed) NEG_A -> NEG_B -> CMP <-> SUB (x32) -> FIX_Q -> FIX_R -> DONE -> IDLE
//          IDLE -> (unsigned) CMP <-> SUB (x32) -> DONE.
//  NEG_A/NEG_B: if operand bit31 set, ALU SUB with da=0, db=operand; store |operand|
//   (|0x80000000| = 0x80000000 unsigned). Otherwise register unchanged; cycle still spent.
//   sign_q = a[31]^b[31], sign_r = a[31] captured at accept.
//  Regs: rem[31:0]=0, quo[31:0]=|a|, div=|b|, cnt[4:0]=0.
//  CMP: S={rem[30:0],quo[31]}, ovf=rem[31]; alu_da=S, alu_db=div, alu_ctl=SLTU;
//   ge = ovf | ~alu_dc[0]; rem<=S; quo<={quo[30:0],ge}; ge_q<=ge.
//  SUB: alu_da=rem, alu_db=div, alu_ctl=SUB; if ge_q rem<=alu_dc (mod 2^32 correct when ovf).
//   cnt increments; after cnt==31 SUB, leave loop.
//  FIX_Q: if sign_q quo<=0-quo via ALU SUB; FIX_R: if sign_r rem<=0-rem. Cycles always spent.
//  DONE: rsp_valid=1, rsp_data = quo (DIV/DIVU) or rem (REM/REMU), stable while rsp_ready=0;
//   rsp_ready=1 -> IDLE next edge, rsp_valid=0. No new accept in the DONE cycle.
//  Latency (accept edge to first rsp_valid cycle): unsigned 65, signed 69, special case 1.
//  Outside CMP/SUB/NEG/FIX: alu_da=alu_db=0, alu_ctl=ADD. req_valid while busy ignored.
//  Responses are 1:1 with accepted requests and in order (one outstanding).
// STRUCTURE
//  Package alu_pkg: ALU_CTL encodings (ADD, SUB, SLTU, ...), div op codes, state enum.
//  Single module; optional sub-module alu_div_dp for rem/quo/div/cnt registers, FSM in top.
//  The ALU itself is instantiated outside; EX muxes its inputs with busy.
// TESTING (bench instantiates alu_div_seq + ALU)
//  DIVU 100/7 -> 14 at 65 cycles; REMU 100/7 -> 2.
//  DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3) at 69 cycles; REM -> 0xFFFFFFFF(-1); REM 7/-2 -> 1.
//  DIVU 0x1234/0 -> 0xFFFFFFFF, REMU -> 0x1234, rsp_valid 1 cycle after accept.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 0xFFFFFFFF/0x80000000 -> 1, REMU -> 0x7FFFFFFF.
//  rsp_ready held 0 for 10 cycles -> rsp_data stable, req_ready=0, second req_valid not accepted.
//  rst_n pulsed low at cnt==10 -> immediate IDLE, req_ready=1, no rsp_valid; next request correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle divide sequencer and the single-cycle ALU it borrows.
package alu_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0010,
    ALU_SLTU = 4'b1000
  } alu_ctl_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_CMP,
    S_SUB,
    S_FIX_Q,
    S_FIX_R,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/alu_div_seq.sv
// RV32M divide sequencer: restoring division driven through the shared ALU,
// one compare and one subtract cycle per quotient bit.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy,
  output logic [XLEN-1:0] alu_da,
  output logic [XLEN-1:0] alu_db,
  output logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] alu_dc
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic [4:0]      cnt_q;
  logic            ge_q, signed_q, neg_quo_q, neg_rem_q, is_rem_q;

  logic            accept, req_signed, b_zero, ovf_case, special;
  logic [XLEN-1:0] shift_in;
  logic            ge;

  assign accept     = req_valid & req_ready;
  assign req_signed = ~req_op[0];
  assign b_zero     = (req_b == '0);
  assign ovf_case   = req_signed & (req_a == MIN_NEG) & (req_b == '1);
  assign special    = b_zero | ovf_case;

  // Bit 31 of rem shifts out into ovf; the 33-bit partial remainder is then always >= div.
  assign shift_in = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign ge       = rem_q[XLEN-1] | ~alu_dc[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : (req_signed ? S_NEG_A : S_CMP);
      S_NEG_A: state_d = S_NEG_B;
      S_NEG_B: state_d = S_CMP;
      S_CMP:   state_d = S_SUB;
      S_SUB:   if (cnt_q == 5'd31) state_d = signed_q ? S_FIX_Q : S_DONE;
               else                state_d = S_CMP;
      S_FIX_Q: state_d = S_FIX_R;
      S_FIX_R: state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    alu_da    = '0;
    alu_db    = '0;
    alu_ctl   = ALU_ADD;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_NEG_A: begin
        alu_db  = quo_q;
        alu_ctl = ALU_SUB;
      end
      S_NEG_B: begin
        alu_db  = div_q;
        alu_ctl = ALU_SUB;
      end
      S_CMP: begin
        alu_da  = shift_in;
        alu_db  = div_q;
        alu_ctl = ALU_SLTU;
      end
      S_SUB: begin
        alu_da  = rem_q;
        alu_db  = div_q;
        alu_ctl = ALU_SUB;
      end
      S_FIX_Q: begin
        alu_db  = quo_q;
        alu_ctl = ALU_SUB;
      end
      S_FIX_R: begin
        alu_db  = rem_q;
        alu_ctl = ALU_SUB;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = is_rem_q ? rem_q : quo_q;
      end
      default: ;
    endcase
  end

  // Operands start raw in quo/div; the NEG states fold them to magnitudes in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      ge_q      <= 1'b0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          is_rem_q  <= req_op[1];
          signed_q  <= req_signed;
          neg_quo_q <= req_a[XLEN-1] ^ req_b[XLEN-1];
          neg_rem_q <= req_a[XLEN-1];
          cnt_q     <= '0;
          ge_q      <= 1'b0;
          div_q     <= req_b;
          if (b_zero) begin
            quo_q <= '1;
            rem_q <= req_a;
          end else if (ovf_case) begin
            quo_q <= MIN_NEG;
            rem_q <= '0;
          end else begin
            quo_q <= req_a;
            rem_q <= '0;
          end
        end
        S_NEG_A: if (quo_q[XLEN-1]) quo_q <= alu_dc;
        S_NEG_B: if (div_q[XLEN-1]) div_q <= alu_dc;
        S_CMP: begin
          rem_q <= shift_in;
          quo_q <= {quo_q[XLEN-2:0], ge};
          ge_q  <= ge;
        end
        S_SUB: begin
          if (ge_q) rem_q <= alu_dc;
          cnt_q <= cnt_q + 5'd1;
        end
        S_FIX_Q: if (neg_quo_q) quo_q <= alu_dc;
        S_FIX_R: if (neg_rem_q) rem_q <= alu_dc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq paired with a behavioural model of the shared ALU.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] alu_da, alu_db, alu_dc;
  logic [3:0]  alu_ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_div_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
    .alu_da(alu_da), .alu_db(alu_db), .alu_ctl(alu_ctl), .alu_dc(alu_dc)
  );

  // Stand-in for the shared single-cycle ALU
  always_comb begin
    case (alu_ctl)
      4'b0000: alu_dc = alu_da + alu_db;
      4'b0010: alu_dc = alu_da - alu_db;
      4'b1000: alu_dc = {31'b0, (alu_da < alu_db)};
      default: alu_dc = '0;
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit drain, output logic [31:0] data, output int lat);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    data = rsp_data;
    if (drain) tick();
  endtask

  task automatic runCase(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expData, input int expLat);
    logic [31:0] data;
    int lat;
    applyStimulus(op, a, b, 1'b1, data, lat);
    checkOutput({tag, "_data"}, data, expData);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
  endtask

  initial begin
    logic [31:0] data;
    int lat;
    int holdBad;
    bit sawValid;

    #2;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_alu_ctl", {28'b0, alu_ctl}, 32'd0);
    checkOutput("rst_alu_da", alu_da, 32'd0);
    checkOutput("rst_alu_db", alu_db, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    runCase("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 65);
    runCase("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 65);
    runCase("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 69);
    runCase("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 69);
    runCase("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 69);
    runCase("divu_by0", 2'b01, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
    runCase("remu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    runCase("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runCase("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    runCase("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 65);
    runCase("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 65);

    // Consumer stalls: response must hold and a second request must wait
    rsp_ready = 1'b0;
    applyStimulus(2'b01, 32'd100, 32'd7, 1'b0, data, lat);
    checkOutput("hold_first_data", data, 32'd14);
    req_op    = 2'b00;
    req_a     = 32'd50;
    req_b     = 32'd5;
    req_valid = 1'b1;
    holdBad   = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_data !== 32'd14 || req_ready !== 1'b0 || rsp_valid !== 1'b1) holdBad++;
    end
    checkOutput("hold_stable", 32'(holdBad), 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checkOutput("hold_release_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("hold_release_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("hold_release_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of the loop (after ten SUB cycles)
    req_op    = 2'b01;
    req_a     = 32'd100;
    req_b     = 32'd7;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (20) tick();
    checkOutput("mid_busy_before", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (5) begin
      tick();
      if (rsp_valid) sawValid = 1'b1;
    end
    checkOutput("mid_rst_no_rsp", {31'b0, sawValid}, 32'd0);
    runCase("after_rst_divu", 2'b01, 32'd1000, 32'd10, 32'd100, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
